fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage feeding decode.
- Holds the PC and issues word requests to instruction memory with a req/ack handshake.
- Captures returned instructions into the IF/ID register, with a one-entry skid buffer for decode stalls.
- Applies branch/jump redirects as a flush.
- Drives the packed `iCtrl_length`-bit field that control_unit decodes, alongside the instruction and PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address/data width.
- M, `iCtrl_length (9), width of id_ictrl.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  word address of the request.
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in that cycle. May assert in the same cycle as imem_req.
- imem_rdata  input  32  returned instruction.
- stall  input  1  decode cannot accept; hold IF/ID.
- redirect_valid  input  1  taken branch/jump from EX.
- redirect_pc  input  XLEN  redirect target.
- id_valid  output  1  IF/ID contents are a real instruction.
- id_instr  output  32  instruction; forced to NOP 32'h0000_0013 when id_valid=0.
- id_pc  output  XLEN  PC of id_instr.
- id_pc4  output  XLEN  id_pc+4.
- id_ictrl  output  M  packed as {id_instr[30], id_instr[14:12], id_instr[6:2]}, i.e. in[8]=I_30, in[7:5]=funct3, in[4:0]=opcode.

Behaviour:
- Reset values (rst=1):
  - pc=RESET_PC, state=FETCH, imem_req=0, buffer empty.
  - id_valid=0, id_instr=NOP, id_pc=0, id_pc4=4, id_ictrl=NOP field (9'b0_000_00100).
- imem_req is combinationally 0 while rst=1; first request is issued in the first cycle after rst falls.
- imem_addr comes from fetch_addr reg and is stable from req assertion until ack. pc arithmetic is mod 2^XLEN, so 32'hFFFF_FFFC+4 wraps to 0.
- FETCH state (req=1, addr=fetch_addr):
  - ack and redirect_valid: drop data; fetch_addr<=redirect_pc; stay FETCH.
  - ack, no redirect, (!id_valid | !stall): IF/ID<={rdata, fetch_addr}, id_valid<=1, fetch_addr+=4.
  - ack, no redirect, id_valid & stall: buffer<={rdata, fetch_addr}, fetch_addr+=4; go BUFFERED.
  - no ack, redirect_valid: target<=redirect_pc; go DRAIN.
- BUFFERED state (req=0):
  - redirect: clear buffer, fetch_addr<=redirect_pc; go FETCH.
  - else !stall: IF/ID<=buffer; go FETCH.
- DRAIN state (req=1, addr=old fetch_addr; the memory cannot cancel a request):
  - further redirect overwrites target.
  - on ack: data discarded, fetch_addr<=target (or redirect_pc if redirect in same cycle); go FETCH.
- IF/ID register:
  - redirect_valid clears id_valid the same edge (flush), regardless of stall. Redirect has priority over stall and over ack.
  - id_valid & !stall with no new instruction loaded: id_valid<=0.
  - stall with id_valid=0 does not block loading.
- Throughput: with ack in the same cycle as req and no stall, one instruction per cycle. Latency from ack to id_valid is 1 cycle.
- Reset mid-transaction: in-flight ack is ignored; the memory must tolerate an abandoned request.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- When defined:
  - Adds output id_misalign (1 bit, reset 0).
  - A redirect_pc with bits[1:0]!=0 issues no request.
  - Next edge loads IF/ID with id_valid=1, id_instr=NOP, id_pc=redirect_pc, id_misalign=1.
  - Fetch then halts in BUFFERED-like idle until the next redirect.
- When undefined:
  - Port is absent.
  - redirect_pc[1:0] is ignored; fetch_addr takes {redirect_pc[XLEN-1:2], 2'b00}.

Decomposition:
- define.v gains: `iCtrl_length (9, existing), `NOP_INSTR 32'h0000_0013, `RESET_PC default, FSM encodings `F_FETCH/`F_BUFFERED/`F_DRAIN (2 bits).
- One sub-module: if_id_reg, the pipeline register with load/clear/hold controls producing id_* outputs and the id_ictrl packing.
- FSM, pc and buffer stay in fetch_unit.

Test Plan:
- Reset then zero-wait memory returning 32'h00500093 at 0, 32'h00A00113 at 4:
  - req at 0,4,8 on consecutive cycles.
  - id_pc 0 then 4.
  - id_ictrl for the first word = 9'b0_000_00100.
- Ack delayed 3 cycles:
  - imem_addr held at 0 and req held high for 3 cycles.
  - id_valid rises exactly 1 cycle after ack.
- stall held 4 cycles while id_valid=1 and one ack arrives:
  - instr enters buffer; req drops.
  - IF/ID holds its pc.
  - On stall release the buffered pc appears next cycle, then fetch resumes at pc+4.
- redirect_valid with redirect_pc=32'h100 while a request to 8 is outstanding:
  - DRAIN keeps addr 8 until ack; its data is never visible.
  - Next request is 0x100; id_valid=0 during drain.
- redirect and stall in the same cycle with id_valid=1:
  - id_valid=0 next cycle; buffer cleared.
  - Fetch of redirect_pc=32'h40 issued.
- FETCH_MISALIGN_EN defined, redirect_pc=32'h102:
  - no imem_req.
  - id_misalign=1, id_pc=32'h102, id_instr=NOP.
  - Without the macro: fetch address is 0x100.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared constants and FSM encodings for the instruction-fetch stage.
//   ICTRL_LENGTH      width of the packed control field handed to control_unit
//   NOP_INSTR         canonical NOP (addi x0, x0, 0) shown when IF/ID is empty
//   RESET_PC_DEFAULT  default first fetch address after reset
//   fetch_state_t     fetch FSM encoding (2 bits)
// Optional feature macro: FETCH_MISALIGN_EN (adds the F_HALT idle state usage).
package fetch_unit_pkg;

  localparam int          ICTRL_LENGTH     = 9;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // F_HALT is only reachable when misaligned redirects are trapped
  // (FETCH_MISALIGN_EN); in the default build it is never entered.
  typedef enum logic [1:0] {
    F_FETCH    = 2'd0,
    F_BUFFERED = 2'd1,
    F_DRAIN    = 2'd2,
    F_HALT     = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg
// IF/ID pipeline register. Load has priority over clear; otherwise the
// contents are held. Outputs are derived from the registered contents:
// the instruction reads as NOP whenever the register is not valid, and the
// control field is packed from that (possibly forced) instruction.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            capture i_instr/i_pc (and i_misalign) and mark valid
//   i_clear           drop valid (flush or consumed by decode)
//   i_instr, i_pc     data to capture
//   i_misalign        (FETCH_MISALIGN_EN only) capture as misaligned marker
//   o_valid           register holds a real instruction
//   o_instr           instruction, NOP when not valid
//   o_pc, o_pc4       PC of o_instr and PC+4
//   o_ictrl           {instr[30], instr[14:12], instr[6:2]}
//   o_misalign        (FETCH_MISALIGN_EN only) misaligned-redirect marker
// Optional feature macro: FETCH_MISALIGN_EN.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic                    i_clear,
  input  logic [31:0]             i_instr,
  input  logic [XLEN-1:0]         i_pc,
`ifdef FETCH_MISALIGN_EN
  input  logic                    i_misalign,
  output logic                    o_misalign,
`endif
  output logic                    o_valid,
  output logic [31:0]             o_instr,
  output logic [XLEN-1:0]         o_pc,
  output logic [XLEN-1:0]         o_pc4,
  output logic [ICTRL_LENGTH-1:0] o_ictrl
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     w_instr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic r_misalign;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misalign <= 1'b0;
    end else if (i_load) begin
      r_misalign <= i_misalign;
    end else if (i_clear) begin
      r_misalign <= 1'b0;
    end
  end

  assign o_misalign = r_misalign;
`endif

  assign w_instr = r_valid ? r_instr : NOP_INSTR;

  assign o_valid = r_valid;
  assign o_instr = w_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc + XLEN'(4);
  assign o_ictrl = {w_instr[30], w_instr[14:12], w_instr[6:2]};

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage: owns the PC, issues word requests to instruction
// memory, captures returned words into IF/ID (via if_id_reg) and holds one
// extra word in a skid buffer when decode stalls. Branch/jump redirects from
// EX flush IF/ID and steer the next fetch.
//
// Memory handshake: imem_req is held high with imem_addr stable until the
// cycle in which imem_ack pulses; imem_rdata is valid only in that ack cycle,
// and ack may arrive in the same cycle the request is first raised. A request
// once raised cannot be withdrawn, so a redirect while a request is in flight
// waits for its ack (F_DRAIN) and throws the data away.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req/imem_addr            fetch request and word address
//   imem_ack/imem_rdata           response pulse and returned instruction
//   stall                         decode cannot accept, hold IF/ID
//   redirect_valid/redirect_pc    taken branch/jump target from EX
//   id_valid/id_instr/id_pc/id_pc4/id_ictrl   IF/ID contents for decode
//   id_misalign                   (FETCH_MISALIGN_EN only) misaligned target
//   o_dbg_state                   current fetch FSM state
// Optional feature macro: FETCH_MISALIGN_EN. When defined, a redirect to a
// non-word-aligned target issues no fetch: IF/ID shows a NOP at that PC with
// id_misalign=1 and fetch idles until the next redirect. When undefined the
// two low target bits are ignored.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              M        = ICTRL_LENGTH
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic [M-1:0]    id_ictrl,
`ifdef FETCH_MISALIGN_EN
  output logic            id_misalign,
`endif
  output logic [1:0]      o_dbg_state
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_addr;
  logic [XLEN-1:0] r_target;
  logic [31:0]     r_buf_instr;
  logic [XLEN-1:0] r_buf_pc;

  logic [XLEN-1:0] w_redir_addr;
  logic            w_redir_mis;
  logic            w_tgt_mis;
  logic [XLEN-1:0] w_drain_addr;
  logic            w_drain_mis;
  logic            w_load_fetch;
  logic            w_load_buf;
  logic            w_load;
  logic            w_clear;
  logic [31:0]     w_ld_instr;
  logic [XLEN-1:0] w_ld_pc;

`ifdef FETCH_MISALIGN_EN
  assign w_redir_addr = redirect_pc;
  assign w_redir_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_tgt_mis    = (r_target[1:0] != 2'b00);
`else
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];
  assign w_redir_addr     = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_redir_mis      = 1'b0;
  assign w_tgt_mis        = 1'b0;
`endif

  // A redirect arriving together with the drain ack wins over the stored target.
  assign w_drain_addr = redirect_valid ? w_redir_addr : r_target;
  assign w_drain_mis  = redirect_valid ? w_redir_mis  : w_tgt_mis;

  assign imem_req    = !rst && ((r_state == F_FETCH) || (r_state == F_DRAIN));
  assign imem_addr   = r_fetch_addr;
  assign o_dbg_state = r_state;

  // IF/ID control. A loaded word goes straight in when IF/ID is empty or
  // being consumed this cycle; redirect flushes regardless of stall, except
  // that a trapped misaligned target loads its NOP marker instead.
  assign w_load_fetch = (r_state == F_FETCH) && imem_ack && !redirect_valid &&
                        (!id_valid || !stall);
  assign w_load_buf   = (r_state == F_BUFFERED) && !redirect_valid && !stall;
  assign w_load       = w_load_fetch || w_load_buf || w_redir_mis;
  assign w_clear      = redirect_valid || (id_valid && !stall);
  assign w_ld_instr   = w_redir_mis ? NOP_INSTR :
                        (w_load_buf ? r_buf_instr : imem_rdata);
  assign w_ld_pc      = w_redir_mis ? redirect_pc :
                        (w_load_buf ? r_buf_pc : r_fetch_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= F_FETCH;
      r_fetch_addr <= RESET_PC;
      r_target     <= RESET_PC;
      r_buf_instr  <= NOP_INSTR;
      r_buf_pc     <= '0;
    end else begin
      case (r_state)
        F_FETCH: begin
          if (imem_ack) begin
            if (redirect_valid) begin
              r_fetch_addr <= w_redir_addr;
              r_state      <= w_redir_mis ? F_HALT : F_FETCH;
            end else begin
              r_fetch_addr <= r_fetch_addr + XLEN'(4);
              if (id_valid && stall) begin
                r_buf_instr <= imem_rdata;
                r_buf_pc    <= r_fetch_addr;
                r_state     <= F_BUFFERED;
              end
            end
          end else if (redirect_valid) begin
            r_target <= w_redir_addr;
            r_state  <= F_DRAIN;
          end
        end
        F_BUFFERED: begin
          if (redirect_valid) begin
            r_buf_instr  <= NOP_INSTR;
            r_fetch_addr <= w_redir_addr;
            r_state      <= w_redir_mis ? F_HALT : F_FETCH;
          end else if (!stall) begin
            r_state <= F_FETCH;
          end
        end
        F_DRAIN: begin
          if (imem_ack) begin
            r_fetch_addr <= w_drain_addr;
            r_state      <= w_drain_mis ? F_HALT : F_FETCH;
          end else if (redirect_valid) begin
            r_target <= w_redir_addr;
          end
        end
        default: begin
          // F_HALT: idle with no request until a new redirect arrives.
          if (redirect_valid) begin
            r_fetch_addr <= w_redir_addr;
            r_state      <= w_redir_mis ? F_HALT : F_FETCH;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_instr    (w_ld_instr),
    .i_pc       (w_ld_pc),
`ifdef FETCH_MISALIGN_EN
    .i_misalign (w_redir_mis),
    .o_misalign (id_misalign),
`endif
    .o_valid    (id_valid),
    .o_instr    (id_instr),
    .o_pc       (id_pc),
    .o_pc4      (id_pc4),
    .o_ictrl    (id_ictrl)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed scenarios followed by a randomized run against an
// instruction-stream reference: decode must see consecutive word PCs with
// the memory's contents, restarting at each redirect target.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [8:0]  id_ictrl;
  logic [1:0]  dbg_state;
`ifdef FETCH_MISALIGN_EN
  logic        id_misalign;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_ictrl       (id_ictrl),
`ifdef FETCH_MISALIGN_EN
    .id_misalign    (id_misalign),
`endif
    .o_dbg_state    (dbg_state)
  );

  // ---------------- memory model ----------------
  int checks = 0;
  int errors = 0;
  int mem_delay = 0;   // <0: random 0..3 cycles per request
  int mem_wait  = 0;
  bit mem_busy  = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [8:0] ictrl_of(input logic [31:0] i);
    logic [31:0] v;
    v = (((i >> 30) & 32'h1) << 8) | (((i >> 12) & 32'h7) << 5) | ((i >> 2) & 32'h1F);
    return v[8:0];
  endfunction

  // Responds a little after each falling edge, so the DUT sees ack/rdata for
  // the whole second half of the cycle.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !imem_req) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (rst) mem_busy = 1'b0;
      end else begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_wait = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        end
        if (mem_wait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          mem_busy   = 1'b0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          mem_wait   = mem_wait - 1;
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  bit          pend;
  int          consumed;

  initial begin
    // ---- reset values ----
    do_reset();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h4);
    chk("rst_ictrl", id_ictrl, 9'b0_000_00100);
    chk("rst_state", dbg_state, F_FETCH);

    // ---- zero-wait streaming ----
    mem_delay = 0;
    rst = 1'b0;
    #2;
    chk("t1_req0", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 32'h0);
    @(negedge clk);
    chk("t1_req4", imem_req, 1'b1);
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_valid", id_valid, 1'b1);
    chk("t1_pc0", id_pc, 32'h0);
    chk("t1_instr0", id_instr, 32'h0050_0093);
    chk("t1_ictrl0", id_ictrl, 9'b0_000_00100);
    @(negedge clk);
    chk("t1_addr8", imem_addr, 32'h8);
    chk("t1_pc4", id_pc, 32'h4);
    chk("t1_instr4", id_instr, 32'h00A0_0113);
    chk("t1_pc4_plus", id_pc4, 32'h8);

    // ---- ack delayed 3 cycles ----
    do_reset();
    mem_delay = 3;
    rst = 1'b0;
    #2;
    chk("t2_req_c0", imem_req, 1'b1);
    chk("t2_addr_c0", imem_addr, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t2_req_c%0d", i), imem_req, 1'b1);
      chk($sformatf("t2_addr_c%0d", i), imem_addr, 32'h0);
      chk($sformatf("t2_valid_c%0d", i), id_valid, 1'b0);
    end
    @(negedge clk);
    chk("t2_valid_after_ack", id_valid, 1'b1);
    chk("t2_pc", id_pc, 32'h0);
    chk("t2_next_addr", imem_addr, 32'h4);

    // ---- stall with one ack -> skid buffer ----
    do_reset();
    mem_delay = 0;
    rst = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_req_drop%0d", i), imem_req, 1'b0);
      chk($sformatf("t3_hold_pc%0d", i), id_pc, 32'h0);
      chk($sformatf("t3_hold_valid%0d", i), id_valid, 1'b1);
      chk($sformatf("t3_state%0d", i), dbg_state, F_BUFFERED);
    end
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    chk("t3_buf_pc", id_pc, 32'h4);
    chk("t3_buf_instr", id_instr, 32'h00A0_0113);
    chk("t3_resume_req", imem_req, 1'b1);
    chk("t3_resume_addr", imem_addr, 32'h8);
    @(negedge clk);
    chk("t3_next_pc", id_pc, 32'h8);
    chk("t3_next_instr", id_instr, mem_word(32'h8));

    // ---- redirect while request to 8 is outstanding ----
    do_reset();
    mem_delay = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mem_delay = 3;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_state", dbg_state, F_DRAIN);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_delay = 0;
      chk($sformatf("t4_drain_req%0d", i), imem_req, 1'b1);
      chk($sformatf("t4_drain_addr%0d", i), imem_addr, 32'h8);
      chk($sformatf("t4_drain_valid%0d", i), id_valid, 1'b0);
      @(negedge clk);
    end
    chk("t4_new_addr", imem_addr, 32'h100);
    chk("t4_new_req", imem_req, 1'b1);
    chk("t4_no_data8", id_valid, 1'b0);
    @(negedge clk);
    chk("t4_valid", id_valid, 1'b1);
    chk("t4_pc", id_pc, 32'h100);
    chk("t4_instr", id_instr, mem_word(32'h100));

    // ---- redirect + stall while buffered ----
    do_reset();
    mem_delay = 0;
    rst = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    stall = 1'b0;
    chk("t5_flush", id_valid, 1'b0);
    chk("t5_req", imem_req, 1'b1);
    chk("t5_addr", imem_addr, 32'h40);
    @(negedge clk);
    chk("t5_valid", id_valid, 1'b1);
    chk("t5_pc", id_pc, 32'h40);

    // ---- misaligned redirect target ----
    do_reset();
    mem_delay = 0;
    rst = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
    chk("t6_no_req", imem_req, 1'b0);
    chk("t6_valid", id_valid, 1'b1);
    chk("t6_pc", id_pc, 32'h102);
    chk("t6_instr", id_instr, NOP);
    chk("t6_misalign", id_misalign, 1'b1);
    @(negedge clk);
    chk("t6_halted", imem_req, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t6_resume_req", imem_req, 1'b1);
    chk("t6_resume_addr", imem_addr, 32'h200);
`else
    chk("t6_valid", id_valid, 1'b0);
    chk("t6_req", imem_req, 1'b1);
    chk("t6_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("t6_pc", id_pc, 32'h100);
`endif

    // ---- PC wrap at top of address space ----
    do_reset();
    mem_delay = 0;
    rst = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t7_pc_top", id_pc, 32'hFFFF_FFFC);
    chk("t7_pc4_wrap", id_pc4, 32'h0);
    chk("t7_addr_wrap", imem_addr, 32'h0);

    // ---- reset during an outstanding request ----
    do_reset();
    mem_delay = 3;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t8_rst_req", imem_req, 1'b0);
    chk("t8_rst_valid", id_valid, 1'b0);
    mem_delay = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("t8_restart_pc", id_pc, 32'h0);
    chk("t8_restart_valid", id_valid, 1'b1);

    // ---- randomized stream against instruction-order reference ----
    do_reset();
    mem_delay = -1;
    rst = 1'b0;
    exp_pc = 32'h0;
    consumed = 0;
    pend = 1'b0;
    pend_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pend) begin
        chk("rnd_req_hold", imem_req, 1'b1);
        chk("rnd_addr_hold", imem_addr, pend_addr);
      end
      if (!id_valid) chk("rnd_nop_when_empty", id_instr, NOP);
      stall = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc = 32'($urandom_range(0, 255)) << 2;
`ifndef FETCH_MISALIGN_EN
      redirect_pc = redirect_pc | 32'($urandom_range(0, 3));
`endif
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (id_valid && !stall) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'h4;
      end
      while (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("rnd_pc", id_pc, e);
        chk("rnd_instr", id_instr, mem_word(e));
        chk("rnd_pc4", id_pc4, e + 32'h4);
        chk("rnd_ictrl", id_ictrl, ictrl_of(mem_word(e)));
        consumed++;
      end
      #2;
      pend = imem_req && !imem_ack;
      pend_addr = imem_addr;
      @(negedge clk);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    chk("rnd_progress", consumed > 300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
